// File: rtl/serial_subtractor_4bit.sv
// ============================================================================
// Module   : serial_subtractor_4bit
// Purpose  : Bit-serial subtractor d = a - b - b_in, LSB first, with a
//            start/done handshake. Optional signed-overflow flag (ovf) is
//            built when SUB_OVF_FLAG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b_out
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cnt;
    logic             br;

    logic             accept;
    logic             last_bit;
    logic             x;
    logic             y;
    logic             dbit;
    logic             br_next;
    logic [WIDTH-1:0] result_next;

    // A new operation may start from IDLE or straight out of DONE.
    assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    assign x           = a_sr[0];
    assign y           = b_sr[0];
    assign dbit        = x ^ y ^ br;
    assign br_next     = (~x & y) | (~(x ^ y) & br);
    assign result_next = {dbit, result[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_next = ST_DONE;
            ST_DONE:  state_next = accept ? ST_SHIFT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_SHIFT);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            result <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            d      <= '0;
            b_out  <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            result <= '0;
            cnt    <= '0;
            br     <= b_in;
        end else if (state == ST_SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            result <= result_next;
            br     <= br_next;
            cnt    <= cnt + CNT_W'(1);
            // Outputs change only here so d/b_out never show a partial result.
            if (last_bit) begin
                d     <= result_next;
                b_out <= br_next;
            end
        end
    end

`ifdef SUB_OVF_FLAG_EN
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if ((state == ST_SHIFT) && last_bit) begin
            ovf <= (a_msb ^ b_msb) & (result_next[WIDTH-1] ^ a_msb);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_4bit.sv
// ============================================================================
// Module   : tb_serial_subtractor_4bit
// Purpose  : Scoreboard bench for serial_subtractor_4bit: directed and random
//            operations checked against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor_4bit;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         b_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         b_out;
`ifdef SUB_OVF_FLAG_EN
    logic         ovf;
`endif

    int   total = 0;
    int   bad = 0;
    int   issued = 0;
    int   done_seen = 0;
    exp_t q[$];

    serial_subtractor_4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .b_out (b_out)
`ifdef SUB_OVF_FLAG_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mbi);
        exp_t e;
        int   diff;
        int   sa;
        int   sb;
        int   sd;
        diff = int'(ma) - int'(mb) - int'(mbi);
        sa   = ma[W-1] ? int'(ma) - (1 << W) : int'(ma);
        sb   = mb[W-1] ? int'(mb) - (1 << W) : int'(mb);
        sd   = sa - sb - int'(mbi);
        e.d  = diff[W-1:0];
        e.bo = (diff < 0);
        e.ov = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the start is sampled on the following posedge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ibi, input bit expect_accept);
        a     = ia;
        b     = ib;
        b_in  = ibi;
        start = 1'b1;
        if (expect_accept) begin
            q.push_back(model(ia, ib, ibi));
            issued++;
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns at the negedge where done is high; edges counts the start edge too.
    task automatic wait_done(output int edges);
        edges = 1;
        while (edges <= 30) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            edges++;
        end
        if (edges > 30) chk("done_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_seen++;
            chk("busy_in_done", int'(busy), 0);
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("d", int'(d), int'(e.d));
                chk("b_out", int'(b_out), int'(e.bo));
`ifdef SUB_OVF_FLAG_EN
                chk("ovf", int'(ovf), int'(e.ov));
`endif
            end
        end
    end

    initial begin
        int lat;

        cyc(2);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_d", int'(d), 0);
        chk("rst_b_out", int'(b_out), 0);
        rst_n = 1'b1;
        cyc(2);
        chk("idle_busy", int'(busy), 0);

        issue(4'd9, 4'd3, 1'b0, 1'b1);
        chk("busy_after_start", int'(busy), 1);
        wait_done(lat);
        chk("latency", lat, W + 1);

        cyc(2);
        issue(4'd3, 4'd9, 1'b0, 1'b1);
        wait_done(lat);
        cyc(10);
        chk("d_held", int'(d), 10);
        chk("b_out_held", int'(b_out), 1);

        issue(4'd0, 4'd0, 1'b1, 1'b1);
        wait_done(lat);
        issue(4'd5, 4'd5, 1'b0, 1'b1);
        wait_done(lat);
        chk("b2b_latency", lat, W + 1);

        cyc(1);
        issue(4'd7, 4'd2, 1'b0, 1'b1);
        cyc(2);
        issue(4'd1, 4'd1, 1'b0, 1'b0);
        wait_done(lat);
        cyc(8);
        chk("single_done", done_seen, issued);

        issue(4'd12, 4'd4, 1'b0, 1'b1);
        cyc(3);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_d", int'(d), 0);
        chk("abort_b_out", int'(b_out), 0);
        void'(q.pop_front());
        issued--;
        cyc(2);
        rst_n = 1'b1;
        cyc(10);
        chk("no_done_after_abort", done_seen, issued);

`ifdef SUB_OVF_FLAG_EN
        issue(4'd8, 4'd1, 1'b0, 1'b1);
        wait_done(lat);
        issue(4'd6, 4'd2, 1'b0, 1'b1);
        wait_done(lat);
        cyc(1);
`endif

        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'b1);
            wait_done(lat);
            chk("rand_latency", lat, W + 1);
            cyc($urandom_range(0, 2));
        end

        cyc(3);
        chk("done_count", done_seen, issued);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
